// File: rtl/window_4x4_gen.sv
// Raster-to-4x4 window generator: three rotating read-first line buffers feed a
// 4x4 shift-register window, one window per accepted pixel once 4x4 pixels exist.
module window_4x4_gen #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 180,
    localparam int XW = $clog2(H_ACTIVE),
    localparam int YW = $clog2(V_ACTIVE)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   pixel_valid_in,
    input  logic                   sof_in,
    input  logic [5:0]             pixel_in,
    output logic [3:0][3:0][5:0]   window_out,
    output logic                   window_valid_out,
    output logic [XW-1:0]          x_out,
    output logic [YW-1:0]          y_out,
    output logic                   frame_done_out
);
    localparam int DATA_W = 6;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    // Assertion is immediate; release is retimed to clk_in.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) rst_sync_q <= '0;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t        state_q, state_d;
    logic [XW-1:0] col_q, col_d, cur_col;
    logic [YW-1:0] row_q, row_d, cur_row;
    logic [1:0]    bsel_q, bsel_d, cur_bsel;
    logic          restart, acc, last_col, last_pix, win_v;

    always_comb begin
        restart  = pixel_valid_in && sof_in;
        acc      = pixel_valid_in && (sof_in || state_q != IDLE);
        cur_col  = restart ? '0 : col_q;
        cur_row  = restart ? '0 : row_q;
        cur_bsel = restart ? 2'd0 : bsel_q;
        last_col = (cur_col == XW'(H_ACTIVE - 1));
        last_pix = last_col && (cur_row == YW'(V_ACTIVE - 1));
        win_v    = acc && !restart && (state_q == RUN) && (cur_col >= XW'(3));
        col_d    = col_q;
        row_d    = row_q;
        bsel_d   = bsel_q;
        state_d  = state_q;
        if (acc) begin
            col_d  = last_col ? '0 : cur_col + XW'(1);
            row_d  = last_col ? cur_row + YW'(1) : cur_row;
            bsel_d = !last_col ? cur_bsel : ((cur_bsel == 2'd2) ? 2'd0 : cur_bsel + 2'd1);
            if (restart)
                state_d = PRIME;
            else if (state_q == PRIME && last_col && cur_row == YW'(2))
                state_d = RUN;
            else if (state_q == RUN && last_pix)
                state_d = IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            bsel_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            bsel_q  <= bsel_d;
        end
    end

    // Stage p0: line-buffer read (read-first returns row r-3 at the written slot)
    logic [DATA_W-1:0] lb_mem [3][H_ACTIVE];
    logic [DATA_W-1:0] rd_p0_q [3];
    logic [DATA_W-1:0] pix_p0_q;
    logic [1:0]        bsel_p0_q;
    logic [XW-1:0]     x_p0_q;
    logic [YW-1:0]     y_p0_q;
    logic              acc_p0_q, vld_p0_q, last_p0_q;

    always_ff @(posedge clk_in) begin
        if (acc) begin
            lb_mem[cur_bsel][cur_col] <= pixel_in;
            for (int b = 0; b < 3; b++) rd_p0_q[b] <= lb_mem[b][cur_col];
            pix_p0_q  <= pixel_in;
            bsel_p0_q <= cur_bsel;
            x_p0_q    <= cur_col - XW'(3);
            y_p0_q    <= cur_row - YW'(3);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0_q  <= 1'b0;
            vld_p0_q  <= 1'b0;
            last_p0_q <= 1'b0;
        end else begin
            acc_p0_q  <= acc;
            vld_p0_q  <= win_v;
            last_p0_q <= win_v && last_pix;
        end
    end

    logic [DATA_W-1:0] top, mid, bot;

    always_comb begin
        case (bsel_p0_q)
            2'd1:    begin top = rd_p0_q[1]; mid = rd_p0_q[2]; bot = rd_p0_q[0]; end
            2'd2:    begin top = rd_p0_q[2]; mid = rd_p0_q[0]; bot = rd_p0_q[1]; end
            default: begin top = rd_p0_q[0]; mid = rd_p0_q[1]; bot = rd_p0_q[2]; end
        endcase
    end

    // Stage p1: window shift and output qualifiers; a restart squashes in-flight valids
    logic [3:0][3:0][DATA_W-1:0] win_q;
    logic [XW-1:0]               x_p1_q;
    logic [YW-1:0]               y_p1_q;
    logic                        vld_p1_q, last_p1_q, done_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (acc_p0_q) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= win_q[r][c+1];
            win_q[0][3] <= top;
            win_q[1][3] <= mid;
            win_q[2][3] <= bot;
            win_q[3][3] <= pix_p0_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            done_q    <= 1'b0;
            x_p1_q    <= '0;
            y_p1_q    <= '0;
        end else begin
            vld_p1_q  <= vld_p0_q && !restart;
            last_p1_q <= last_p0_q && !restart;
            done_q    <= vld_p1_q && last_p1_q && !restart;
            if (vld_p0_q) begin
                x_p1_q <= x_p0_q;
                y_p1_q <= y_p0_q;
            end
        end
    end

    assign window_out       = win_q;
    assign window_valid_out = vld_p1_q;
    assign x_out            = x_p1_q;
    assign y_out            = y_p1_q;
    assign frame_done_out   = done_q;

endmodule

// File: tb/tb_window_4x4_gen.sv
// Directed bench for window_4x4_gen on a small 6x5 frame; pixel (c,r) carries
// (off + 8*r + c) mod 64 so every window content is predictable.
module tb_window_4x4_gen;
    localparam int H = 6;
    localparam int V = 5;

    logic                 clk_in = 1'b0;
    logic                 rst_n_in = 1'b0;
    logic                 pixel_valid_in = 1'b0;
    logic                 sof_in = 1'b0;
    logic [5:0]           pixel_in = '0;
    logic [3:0][3:0][5:0] window_out;
    logic                 window_valid_out;
    logic [2:0]           x_out;
    logic [2:0]           y_out;
    logic                 frame_done_out;

    int errors = 0;
    int checks = 0;

    window_4x4_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .pixel_valid_in  (pixel_valid_in),
        .sof_in          (sof_in),
        .pixel_in        (pixel_in),
        .window_out      (window_out),
        .window_valid_out(window_valid_out),
        .x_out           (x_out),
        .y_out           (y_out),
        .frame_done_out  (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [5:0] pix(input int c, input int r, input int off);
        return 6'((off + r * 8 + c) % 64);
    endfunction

    function automatic logic [3:0][3:0][5:0] exp_win(input int x, input int y, input int off);
        logic [3:0][3:0][5:0] w;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[i][j] = pix(x + j, y + i, off);
        return w;
    endfunction

    // Applies inputs for one cycle; returns at the next falling edge.
    task automatic drive(input bit v, input bit s, input logic [5:0] p);
        pixel_valid_in = v;
        sof_in         = s;
        pixel_in       = p;
        @(negedge clk_in);
        pixel_valid_in = 1'b0;
        sof_in         = 1'b0;
    endtask

    task automatic test_reset;
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (window_valid_out !== 1'b0 || frame_done_out !== 1'b0 || x_out !== 3'd0 || y_out !== 3'd0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b done=%b x=%0d y=%0d, want all 0",
                     window_valid_out, frame_done_out, x_out, y_out);
        end
        checks++;
        if (window_out !== '0) begin
            errors++;
            $display("FAIL reset_window: got %h, want 0", window_out);
        end
        rst_n_in = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    // Streams one frame starting with sof; gap_mod>0 inserts an idle slot every gap_mod slots.
    task automatic test_frame(input int off, input int gap_mod, input string tag);
        int k, flush, slot, nobs, ex, ey, nx, ny, c, r;
        bit ev, ed, nv, gap;
        logic [3:0][3:0][5:0] ew;
        k = 0; flush = 0; slot = 0; nobs = 0;
        ev = 1'b0; ed = 1'b0; ex = 0; ey = 0; ew = '0;
        while (k < H * V || flush < 3) begin
            gap = (k >= H * V) || (gap_mod != 0 && (slot % gap_mod) == gap_mod - 1);
            nv = 1'b0; nx = 0; ny = 0;
            if (gap) begin
                drive(1'b0, 1'b0, 6'd0);
                if (k >= H * V) flush++;
            end else begin
                c = k % H;
                r = k / H;
                drive(1'b1, k == 0, pix(c, r, off));
                nv = (r >= 3 && c >= 3);
                nx = c - 3;
                ny = r - 3;
                k++;
            end
            if (window_valid_out === 1'b1) nobs++;
            checks++;
            if (window_valid_out !== ev) begin
                errors++;
                $display("FAIL %s_valid slot=%0d: got %b, want %b", tag, slot, window_valid_out, ev);
            end
            checks++;
            if (frame_done_out !== ed) begin
                errors++;
                $display("FAIL %s_done slot=%0d: got %b, want %b", tag, slot, frame_done_out, ed);
            end
            if (ev) begin
                ew = exp_win(ex, ey, off);
                checks++;
                if (x_out !== 3'(ex) || y_out !== 3'(ey)) begin
                    errors++;
                    $display("FAIL %s_xy slot=%0d: got (%0d,%0d), want (%0d,%0d)", tag, slot, x_out, y_out, ex, ey);
                end
                checks++;
                if (window_out !== ew) begin
                    errors++;
                    $display("FAIL %s_window (%0d,%0d): got %h, want %h", tag, ex, ey, window_out, ew);
                end
            end
            ed = ev && ex == H - 4 && ey == V - 4;
            ev = nv; ex = nx; ey = ny;
            slot++;
        end
        checks++;
        if (nobs != (H - 3) * (V - 3)) begin
            errors++;
            $display("FAIL %s_count: got %0d windows, want %0d", tag, nobs, (H - 3) * (V - 3));
        end
        checks++;
        if (window_out !== ew) begin
            errors++;
            $display("FAIL %s_hold: got %h, want %h", tag, window_out, ew);
        end
    endtask

    task automatic test_idle_drop;
        logic [3:0][3:0][5:0] held;
        held = exp_win(H - 4, V - 4, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 6'(i + 50));
            checks++;
            if (window_valid_out !== 1'b0 || frame_done_out !== 1'b0) begin
                errors++;
                $display("FAIL idle_drop cyc=%0d: valid=%b done=%b, want 0 0", i, window_valid_out, frame_done_out);
            end
        end
        drive(1'b0, 1'b0, 6'd0);
        checks++;
        if (window_out !== held) begin
            errors++;
            $display("FAIL idle_drop_window: got %h, want %h", window_out, held);
        end
    endtask

    // A frame cut short by sof: the first in-flight valid must be squashed.
    task automatic test_sof_restart;
        for (int k = 0; k < 22; k++) drive(1'b1, k == 0, pix(k % H, k / H, 9));
        test_frame(21, 0, "restart_mid");
        for (int k = 0; k < H * V; k++) drive(1'b1, k == 0, pix(k % H, k / H, 12));
        test_frame(44, 2, "restart_end");
    endtask

    task automatic test_reset_mid_frame;
        for (int k = 0; k < 22; k++) drive(1'b1, k == 0, pix(k % H, k / H, 5));
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (window_valid_out !== 1'b0 || frame_done_out !== 1'b0 || x_out !== 3'd0 ||
            y_out !== 3'd0 || window_out !== '0) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b done=%b x=%0d y=%0d win=%h, want all 0",
                     window_valid_out, frame_done_out, x_out, y_out, window_out);
        end
        @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 6'(i + 7));
            checks++;
            if (window_valid_out !== 1'b0 || frame_done_out !== 1'b0 || window_out !== '0) begin
                errors++;
                $display("FAIL rstmid_held cyc=%0d: valid=%b done=%b win=%h, want 0", i,
                         window_valid_out, frame_done_out, window_out);
            end
        end
        rst_n_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 6'd0);
            checks++;
            if (window_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_release cyc=%0d: valid=%b, want 0", i, window_valid_out);
            end
        end
        test_frame(33, 0, "after_reset");
    endtask

    initial begin
        @(negedge clk_in);
        test_reset;
        test_frame(0, 0, "continuous");
        test_idle_drop;
        test_frame(17, 3, "gapped");
        test_frame(30, 0, "back_to_back");
        test_sof_restart;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
